exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 136 +++++++++++++
 tb/tb_exception_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception/interrupt arbiter feeding CP0, pipeline flush/stall and fetch redirect.
// Build option INT_SYNC_EN: int_i passes through SYNC_STAGES flops; undefined, int_sync_o follows int_i directly.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic        redirect_ready_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic [5:0]  int_sync_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  // state    | meaning
  // IDLE     | accepting requests; the take cycle drives the CP0 outputs combinationally
  // FLUSH    | single flush cycle following a take
  // REDIRECT | redirect held to fetch until redirect_ready_i
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t      r_state;
  logic        r_flush;
  logic        r_stall;
  logic        r_rvalid;
  logic [31:0] r_rpc;

  logic        w_int_pend;
  logic        w_take;
  logic [7:0]  w_code;
  logic [31:0] w_bad;
  logic        w_is_eret;

  assign w_int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  // Gated by rst so that nothing combinational leaks out while reset is held.
  assign w_take = rst & (r_state == S_IDLE) & mem_valid_i & (w_int_pend | (|mem_exc_i));

  always_comb begin
    w_code    = 8'h00;
    w_bad     = 32'h0;
    w_is_eret = 1'b0;
    if (w_int_pend)        w_code = 8'h01;
    else if (mem_exc_i[0]) begin w_code = 8'h04; w_bad = mem_pc_i; end
    else if (mem_exc_i[1]) w_code = 8'h0a;
    else if (mem_exc_i[2]) w_code = 8'h0c;
    else if (mem_exc_i[3]) w_code = 8'h08;
    else if (mem_exc_i[4]) w_code = 8'h09;
    else if (mem_exc_i[5]) begin w_code = 8'h04; w_bad = mem_badaddr_i; end
    else if (mem_exc_i[6]) begin w_code = 8'h05; w_bad = mem_badaddr_i; end
    else if (mem_exc_i[7]) begin w_code = 8'h0e; w_is_eret = 1'b1; end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_flush  <= 1'b0;
      r_stall  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rpc    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
            r_stall <= 1'b1;
            r_rpc   <= w_is_eret ? epc_i : EXC_VECTOR;
          end
        end
        S_FLUSH: begin
          r_state  <= S_REDIRECT;
          r_flush  <= 1'b0;
          r_rvalid <= 1'b1;
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            r_state  <= S_IDLE;
            r_stall  <= 1'b0;
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_flush  <= 1'b0;
          r_stall  <= 1'b0;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign excepttype_o        = w_take ? {24'h0, w_code} : 32'h0;
  assign current_inst_addr_o = w_take ? mem_pc_i : 32'h0;
  assign is_in_delayslot_o   = w_take & mem_in_delayslot_i;
  assign bad_addr_o          = w_take ? w_bad : 32'h0;
  assign flush_o             = w_take | r_flush;
  assign stall_o             = r_stall;
  assign redirect_valid_o    = r_rvalid;
  assign redirect_pc_o       = r_rpc;

`ifdef INT_SYNC_EN
  logic [5:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 6'h0;
    end else begin
      r_sync[0] <= int_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign int_sync_o = r_sync[SYNC_STAGES-1];
`else
  assign int_sync_o = rst ? int_i : 6'h0;
  wire [31:0] w_unused_stages = SYNC_STAGES;
`endif

  // Only IE/EXL and the interrupt mask/pending fields matter here.
  wire w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: scenario tasks queue per-cycle expectations, a negedge monitor compares.
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] status_i, cause_i, epc_i, mem_pc_i, mem_badaddr_i;
  logic        mem_valid_i, mem_in_delayslot_i, redirect_ready_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, redirect_pc_o;
  logic        is_in_delayslot_o, flush_o, stall_o, redirect_valid_o;
  logic [5:0]  int_sync_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] etype;
    logic [31:0] cia;
    logic [31:0] bad;
    logic        dly;
    logic        flush;
    logic        stall;
    logic        rv;
    logic        chk_rpc;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  exception_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_exc_i(mem_exc_i),
    .mem_badaddr_i(mem_badaddr_i), .redirect_ready_i(redirect_ready_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .int_sync_o(int_sync_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t e_base(string n);
    exp_t e;
    e.name = n; e.etype = 32'h0; e.cia = 32'h0; e.bad = 32'h0; e.dly = 1'b0;
    e.flush = 1'b0; e.stall = 1'b0; e.rv = 1'b0; e.chk_rpc = 1'b0; e.rpc = 32'h0;
    return e;
  endfunction

  function automatic exp_t e_take(string n, logic [31:0] code, logic [31:0] pc,
                                  logic [31:0] bad, logic dly);
    exp_t e = e_base(n);
    e.etype = code; e.cia = pc; e.bad = bad; e.dly = dly; e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_flush(string n);
    exp_t e = e_base(n);
    e.flush = 1'b1; e.stall = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_redir(string n, logic [31:0] pc);
    exp_t e = e_base(n);
    e.stall = 1'b1; e.rv = 1'b1; e.chk_rpc = 1'b1; e.rpc = pc;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (excepttype_o !== mon_e.etype) begin
        errors++; $display("FAIL %s excepttype got %h want %h", mon_e.name, excepttype_o, mon_e.etype);
      end
      checks++;
      if (current_inst_addr_o !== mon_e.cia) begin
        errors++; $display("FAIL %s inst_addr got %h want %h", mon_e.name, current_inst_addr_o, mon_e.cia);
      end
      checks++;
      if (bad_addr_o !== mon_e.bad) begin
        errors++; $display("FAIL %s bad_addr got %h want %h", mon_e.name, bad_addr_o, mon_e.bad);
      end
      checks++;
      if (is_in_delayslot_o !== mon_e.dly) begin
        errors++; $display("FAIL %s delayslot got %b want %b", mon_e.name, is_in_delayslot_o, mon_e.dly);
      end
      checks++;
      if ({flush_o, stall_o, redirect_valid_o} !== {mon_e.flush, mon_e.stall, mon_e.rv}) begin
        errors++; $display("FAIL %s flush/stall/rvalid got %b%b%b want %b%b%b", mon_e.name,
                           flush_o, stall_o, redirect_valid_o, mon_e.flush, mon_e.stall, mon_e.rv);
      end
      if (mon_e.chk_rpc) begin
        checks++;
        if (redirect_pc_o !== mon_e.rpc) begin
          errors++; $display("FAIL %s redirect_pc got %h want %h", mon_e.name, redirect_pc_o, mon_e.rpc);
        end
      end
    end
  end

  task automatic clear_mem();
    mem_valid_i = 1'b0; mem_exc_i = 8'h00; mem_in_delayslot_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; int_i = 6'h3f; status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
    mem_pc_i = 32'h80000000; mem_badaddr_i = 32'h0; redirect_ready_i = 1'b1;
    mem_valid_i = 1'b1; mem_exc_i = 8'h08; mem_in_delayslot_i = 1'b1;
    #2;
    checks++;
    if ({excepttype_o, current_inst_addr_o, bad_addr_o, redirect_pc_o} !== 128'h0) begin
      errors++; $display("FAIL reset_words got %h %h %h %h want 0", excepttype_o,
                         current_inst_addr_o, bad_addr_o, redirect_pc_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({is_in_delayslot_o, flush_o, stall_o, redirect_valid_o, int_sync_o} !== 10'h0) begin
      errors++; $display("FAIL reset_bits got %b%b%b%b %h want 0", is_in_delayslot_o, flush_o,
                         stall_o, redirect_valid_o, int_sync_o);
    end
    int_i = 6'h0;
    clear_mem();
    rst = 1'b1;
    step(e_base("post_reset_idle"));
  endtask

  task automatic test_syscall();
    mem_valid_i = 1'b1; mem_exc_i = 8'h08; mem_pc_i = 32'h80001000; redirect_ready_i = 1'b1;
    step(e_take("sys_take", 32'h08, 32'h80001000, 32'h0, 1'b0));
    clear_mem();
    step(e_flush("sys_flush"));
    step(e_redir("sys_redir", VEC));
    redirect_ready_i = 1'b0;
    step(e_base("sys_idle"));
  endtask

  task automatic test_priority();
    mem_valid_i = 1'b1; mem_exc_i = 8'h06; mem_pc_i = 32'h80001100; mem_in_delayslot_i = 1'b1;
    step(e_take("prio_ri_ov", 32'h0a, 32'h80001100, 32'h0, 1'b1));
    clear_mem(); redirect_ready_i = 1'b1;
    step(e_flush("prio_flush1"));
    step(e_redir("prio_redir1", VEC));
    redirect_ready_i = 1'b0;
    // EXL set masks the interrupt: nothing is taken.
    status_i = 32'h00000403; cause_i = 32'h00000400; mem_valid_i = 1'b1;
    step(e_base("prio_exl_masked"));
    status_i = 32'h00000401; mem_exc_i = 8'h01; mem_pc_i = 32'h80001200;
    step(e_take("prio_int", 32'h01, 32'h80001200, 32'h0, 1'b0));
    clear_mem(); status_i = 32'h0; cause_i = 32'h0; redirect_ready_i = 1'b1;
    step(e_flush("prio_flush2"));
    step(e_redir("prio_redir2", VEC));
    redirect_ready_i = 1'b0;
    step(e_base("prio_idle"));
  endtask

  task automatic test_eret();
    epc_i = 32'h80002004; mem_valid_i = 1'b1; mem_exc_i = 8'h80; mem_pc_i = 32'h80001300;
    step(e_take("eret_take", 32'h0e, 32'h80001300, 32'h0, 1'b0));
    mem_exc_i = 8'h10;
    epc_i = 32'h12345678;
    step(e_flush("eret_flush"));
    for (int i = 0; i < 5; i++) step(e_redir("eret_hold", 32'h80002004));
    redirect_ready_i = 1'b1;
    step(e_redir("eret_accept", 32'h80002004));
    clear_mem(); redirect_ready_i = 1'b0;
    step(e_base("eret_idle"));
  endtask

  task automatic test_back_to_back();
    mem_valid_i = 1'b1; mem_exc_i = 8'h40; mem_badaddr_i = 32'h00000003; mem_pc_i = 32'h80001400;
    step(e_take("ades_take", 32'h05, 32'h80001400, 32'h00000003, 1'b0));
    mem_exc_i = 8'h10; redirect_ready_i = 1'b1;
    step(e_flush("break_in_flush"));
    step(e_redir("b2b_redir", VEC));
    mem_exc_i = 8'h01; mem_pc_i = 32'h80003000;
    step(e_take("adel_fetch_take", 32'h04, 32'h80003000, 32'h80003000, 1'b0));
    clear_mem();
    step(e_flush("b2b_flush2"));
    step(e_redir("b2b_redir2", VEC));
    mem_valid_i = 1'b1; mem_exc_i = 8'h20; mem_badaddr_i = 32'h00000011; mem_pc_i = 32'h80003100;
    step(e_take("adel_load_take", 32'h04, 32'h80003100, 32'h00000011, 1'b0));
    clear_mem();
    step(e_flush("b2b_flush3"));
    step(e_redir("b2b_redir3", VEC));
    mem_valid_i = 1'b0; mem_exc_i = 8'hff;
    step(e_base("invalid_ignored"));
    clear_mem(); redirect_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_valid_i = 1'b1; mem_exc_i = 8'h08; mem_pc_i = 32'h80004000;
    step(e_take("rmid_take", 32'h08, 32'h80004000, 32'h0, 1'b0));
    clear_mem();
    step(e_flush("rmid_flush"));
    step(e_redir("rmid_redir", VEC));
    rst = 1'b0;
    #1;
    checks++;
    if ({flush_o, stall_o, redirect_valid_o, redirect_pc_o, excepttype_o} !== 67'h0) begin
      errors++; $display("FAIL rmid_reset got %b%b%b %h %h want 0", flush_o, stall_o,
                         redirect_valid_o, redirect_pc_o, excepttype_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(e_base("rmid_released"));
    mem_valid_i = 1'b1; mem_exc_i = 8'h08; mem_pc_i = 32'h80004100; redirect_ready_i = 1'b1;
    step(e_take("rmid_sys_take", 32'h08, 32'h80004100, 32'h0, 1'b0));
    clear_mem();
    step(e_flush("rmid_sys_flush"));
    step(e_redir("rmid_sys_redir", VEC));
    redirect_ready_i = 1'b0;
    step(e_base("rmid_sys_idle"));
  endtask

  task automatic test_sync();
`ifdef INT_SYNC_EN
    int_i = 6'h20;
    @(posedge clk); #1;
    checks++;
    if (int_sync_o !== 6'h00) begin
      errors++; $display("FAIL sync_edge1 got %h want 00", int_sync_o);
    end
    @(posedge clk); #1;
    checks++;
    if (int_sync_o !== 6'h20) begin
      errors++; $display("FAIL sync_edge2 got %h want 20", int_sync_o);
    end
`else
    int_i = 6'h20;
    #1;
    checks++;
    if (int_sync_o !== 6'h20) begin
      errors++; $display("FAIL sync_pass got %h want 20", int_sync_o);
    end
    int_i = 6'h15;
    #1;
    checks++;
    if (int_sync_o !== 6'h15) begin
      errors++; $display("FAIL sync_pass2 got %h want 15", int_sync_o);
    end
`endif
    int_i = 6'h0;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_priority();
    test_eret();
    test_back_to_back();
    test_reset_mid();
    test_sync();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
